hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It drives the write-enable and flush inputs of the IF/ID and ID/EX pipeline registers and the PC write enable. It resolves four cases: load-use data hazards, branch mispredictions detected in EX, and multi-cycle data-memory waits, with a timeout error for waits that never complete. It also keeps performance counters for stall cycles and flush events.

## Interface
Parameters:
- TIMEOUT, default 64: maximum number of wait cycles allowed for one memory access before the error state is entered.

Ports (clock `clk`, one clock domain; reset `rst` is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_memread  in  1  the EX instruction is a load
- ex_is_branch  in  1  the EX instruction is a conditional branch or jump
- ex_br_taken  in  1  resolved direction in EX
- ex_br_pred  in  1  predicted direction, as carried through IF/ID and ID/EX
- mem_req  in  1  the MEM stage is accessing data memory this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable (0 = hold)
- dflush  out  1  clear IF/ID at the next edge
- eflush  out  1  clear ID/EX at the next edge
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- redirect  out  1  PC mux selects the EX correction target
- mem_err  out  1  sticky timeout flag
- stall_cnt  out  32  cycles with pc_write=0 outside reset
- flush_cnt  out  32  mispredict flush events

## Operation
Memory FSM, with state held in registers:
- IDLE → WAIT when mem_req=1 and mem_ready=0. The wait counter is loaded with 1.
- WAIT → IDLE when mem_ready=1.
- WAIT → ERR when the wait counter reaches TIMEOUT. Otherwise the counter increments each cycle.
- ERR is left only by rst. mem_err=1 while in ERR.

Hazard terms (combinational):
- mem_hold = (IDLE and mem_req and !mem_ready) or (WAIT and !mem_ready) or ERR.
- mispredict = ex_is_branch and (ex_br_taken != ex_br_pred).
- load_use = ex_memread, ex_rd != 0, and ((id_use_rs1 and id_rs1 == ex_rd) or (id_use_rs2 and id_rs2 == ex_rd)).

Output priority is rst > mem_hold > mispredict > load_use > normal:
- rst: pc_write=0, ifid_write=0, dflush=1, eflush=1, freeze=0, redirect=0. The pipeline registers have no reset of their own, so this clears them.
- mem_hold: freeze=1, pc_write=0, ifid_write=0, no flushes, redirect=0. A pending mispredict or load-use is not lost, because EX is held and the condition is re-evaluated after the hold.
- mispredict: redirect=1, pc_write=1, dflush=1, eflush=1, ifid_write=1. Load-use is ignored in the same cycle, because the ID instruction is squashed.
- load_use: pc_write=0, ifid_write=0, eflush=1 (inserts one bubble). The hazard clears on the next cycle because the load has moved to MEM.
- normal: pc_write=1, ifid_write=1, all other controls 0.

Counters:
- stall_cnt increments on every non-reset cycle with pc_write=0.
- flush_cnt increments on every cycle in which the mispredict branch is taken.
- Both are 32-bit, wrap modulo 2^32, and clear to 0 on rst.

## Timing
- Reset values: state=IDLE, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. The combinational outputs take their reset values, as listed above.
- All control outputs are combinational from the inputs and the registered state, with zero latency. They act at the next rising edge of clk.
- The load-use bubble lasts exactly 1 cycle.
- A mispredict flush lasts 1 cycle and costs 2 squashed instructions.
- A memory wait holds for N cycles, where N is the number of cycles with mem_ready=0.
- mem_req=1 together with mem_ready=1 in IDLE: no stall and no state change.
- A timeout enters ERR on the cycle after the counter equals TIMEOUT.
- rst asserted in WAIT or ERR returns to IDLE at the next edge.

## Test plan
- Load-use: lw x5 in EX (ex_memread=1, ex_rd=5) with id_rs1=5, id_use_rs1=1 → for one cycle pc_write=0, ifid_write=0, eflush=1; then normal; stall_cnt=1.
- ex_rd=0 with a matching id_rs1=0 → no stall.
- Mispredict: ex_is_branch=1, ex_br_pred=0, ex_br_taken=1, with a simultaneous load_use → redirect=1, dflush=1, eflush=1, pc_write=1; flush_cnt=1.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles → freeze=1 and pc_write=0 for 3 cycles, released in the ready cycle; stall_cnt=3. A pending mispredict during the wait produces its flush only after release.
- Timeout: TIMEOUT=4 and mem_ready never asserted → mem_err=1 and freeze stays high; rst restores IDLE, mem_err=0 and both counters=0.
- Reset: rst=1 for 2 cycles → dflush=1, eflush=1, pc_write=0 in both cycles.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the pipeline-side signals seen by the hazard
// controller.
//   ID/EX inputs : id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
//                  ex_memread, ex_is_branch, ex_br_taken, ex_br_pred
//   MEM inputs   : mem_req, mem_ready
//   Controls     : pc_write, ifid_write, dflush, eflush, freeze, redirect
//   Status       : mem_err, stall_cnt, flush_cnt
// The master modport is the controller; the slave modport is the pipeline.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        ex_is_branch;
  logic        ex_br_taken;
  logic        ex_br_pred;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        dflush;
  logic        eflush;
  logic        freeze;
  logic        redirect;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_is_branch, ex_br_taken, ex_br_pred, mem_req, mem_ready,
    output pc_write, ifid_write, dflush, eflush, freeze, redirect,
           mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_is_branch, ex_br_taken, ex_br_pred, mem_req, mem_ready,
    input  pc_write, ifid_write, dflush, eflush, freeze, redirect,
           mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for the 5-stage RISC-V pipeline.
// Resolves memory waits (with timeout), branch mispredicts and load-use
// hazards in that priority, and drives the PC / IF/ID / ID/EX enables and
// flushes. Also counts stall cycles and mispredict flushes.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset; also flushes IF/ID and ID/EX
//   bus  - hazard_ctrl_if.master (pipeline status in, controls/status out)
// Parameter TIMEOUT: maximum wait cycles for one memory access before ERR.
module hazard_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } mem_state_t;

  mem_state_t    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic [31:0]   stall_cnt, flush_cnt;

  logic mem_hold;
  logic mispredict;
  logic load_use;
  logic take_flush;

  logic pc_write, ifid_write, dflush, eflush, freeze, redirect;

  // Memory FSM state and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (!pc_write)  stall_cnt <= stall_cnt + 32'd1;
      if (take_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  // Next-state: a completing access always wins over the timeout check
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = CW'(1);
        end
      end
      S_WAIT: begin
        if (bus.mem_ready) begin
          state_nxt    = S_IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          state_nxt = S_ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Hazard terms
  always_comb begin
    mem_hold = ((state == S_IDLE) && bus.mem_req && !bus.mem_ready) ||
               ((state == S_WAIT) && !bus.mem_ready) ||
               (state == S_ERR);
    mispredict = bus.ex_is_branch && (bus.ex_br_taken != bus.ex_br_pred);
    load_use   = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                 ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                  (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // Control outputs, priority rst > mem_hold > mispredict > load_use.
  // A held mispredict/load-use is re-evaluated once the hold drops since EX
  // is frozen meanwhile.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    dflush     = 1'b0;
    eflush     = 1'b0;
    freeze     = 1'b0;
    redirect   = 1'b0;
    take_flush = 1'b0;
    if (rst) begin
      // Pipeline registers have no reset; flushing clears them.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      dflush     = 1'b1;
      eflush     = 1'b1;
    end else if (mem_hold) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (mispredict) begin
      redirect   = 1'b1;
      dflush     = 1'b1;
      eflush     = 1'b1;
      take_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      eflush     = 1'b1;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.dflush     = dflush;
  assign bus.eflush     = eflush;
  assign bus.freeze     = freeze;
  assign bus.redirect   = redirect;
  assign bus.mem_err    = (state == S_ERR);
  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: an outstanding access is tracked as "cycles waited so
  // far" (0 = none outstanding) plus a sticky error bit.
  int          m_pend;
  bit          m_err;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  logic e_pc, e_ifid, e_df, e_ef, e_fr, e_rd;
  bit   e_flush_evt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_outputs();
    bit hold, mp, lu;
    hold = m_err || (!hif.mem_ready && (m_pend > 0 || hif.mem_req));
    mp   = hif.ex_is_branch && (hif.ex_br_taken != hif.ex_br_pred);
    lu   = hif.ex_memread && hif.ex_rd != 0 &&
           ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) ||
            (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
    {e_pc, e_ifid, e_df, e_ef, e_fr, e_rd} = 6'b110000;
    e_flush_evt = 0;
    if (rst)       {e_pc, e_ifid, e_df, e_ef, e_fr, e_rd} = 6'b001100;
    else if (hold) {e_pc, e_ifid, e_df, e_ef, e_fr, e_rd} = 6'b000010;
    else if (mp) begin
      {e_pc, e_ifid, e_df, e_ef, e_fr, e_rd} = 6'b111101;
      e_flush_evt = 1;
    end
    else if (lu)   {e_pc, e_ifid, e_df, e_ef, e_fr, e_rd} = 6'b000100;
  endtask

  task automatic model_update();
    if (rst) begin
      m_pend = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc) m_stall = m_stall + 32'd1;
      if (e_flush_evt) m_flush = m_flush + 32'd1;
      if (m_err) begin
      end else if (m_pend > 0) begin
        if (hif.mem_ready) m_pend = 0;
        else if (m_pend == TMO) begin m_err = 1; m_pend = 0; end
        else m_pend++;
      end else if (hif.mem_req && !hif.mem_ready) begin
        m_pend = 1;
      end
    end
  endtask

  // One clock: compare all outputs at the falling edge, then advance model.
  task automatic cycle();
    @(negedge clk);
    model_outputs();
    chk("pc_write",   32'(hif.pc_write),   32'(e_pc));
    chk("ifid_write", 32'(hif.ifid_write), 32'(e_ifid));
    chk("dflush",     32'(hif.dflush),     32'(e_df));
    chk("eflush",     32'(hif.eflush),     32'(e_ef));
    chk("freeze",     32'(hif.freeze),     32'(e_fr));
    chk("redirect",   32'(hif.redirect),   32'(e_rd));
    chk("mem_err",    32'(hif.mem_err),    32'(m_err));
    chk("stall_cnt",  hif.stall_cnt,       m_stall);
    chk("flush_cnt",  hif.flush_cnt,       m_flush);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic quiet();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0;
    hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
    hif.ex_rd = 5'd0; hif.ex_memread = 1'b0;
    hif.ex_is_branch = 1'b0; hif.ex_br_taken = 1'b0; hif.ex_br_pred = 1'b0;
    hif.mem_req = 1'b0; hif.mem_ready = 1'b1;
  endtask

  initial begin
    m_pend = 0; m_err = 0; m_stall = 0; m_flush = 0;
    quiet();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_stall_cnt", hif.stall_cnt, 32'd0);
    chk("rst_mem_err", 32'(hif.mem_err), 32'd0);

    // Load-use: lw x5 in EX, ID reads x5
    hif.ex_memread = 1'b1; hif.ex_rd = 5'd5;
    hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
    cycle();
    chk("lu_stall_cnt", hif.stall_cnt, 32'd1);
    quiet();
    cycle();
    chk("lu_after_stall_cnt", hif.stall_cnt, 32'd1);

    // x0 never creates a hazard
    hif.ex_memread = 1'b1; hif.ex_rd = 5'd0;
    hif.id_rs1 = 5'd0; hif.id_use_rs1 = 1'b1;
    #1 chk("x0_pc_write", 32'(hif.pc_write), 32'd1);
    cycle();

    // Mispredict together with load-use: flush wins
    hif.ex_rd = 5'd7; hif.id_rs2 = 5'd7; hif.id_use_rs2 = 1'b1;
    hif.ex_is_branch = 1'b1; hif.ex_br_pred = 1'b0; hif.ex_br_taken = 1'b1;
    #1 chk("mp_redirect", 32'(hif.redirect), 32'd1);
    cycle();
    chk("mp_flush_cnt", hif.flush_cnt, 32'd1);
    quiet();

    // Memory wait of 3 cycles with a mispredict pending in EX
    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    hif.ex_is_branch = 1'b1; hif.ex_br_pred = 1'b1; hif.ex_br_taken = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    hif.mem_ready = 1'b1;
    #1 chk("wait_release_redirect", 32'(hif.redirect), 32'd1);
    cycle();
    chk("wait_stall_cnt", hif.stall_cnt, 32'd4);
    chk("wait_flush_cnt", hif.flush_cnt, 32'd2);
    quiet();
    cycle();

    // Timeout: ready never comes
    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("tmo_mem_err", 32'(hif.mem_err), 32'd1);
    hif.mem_req = 1'b0; hif.mem_ready = 1'b1;
    #1 chk("tmo_freeze", 32'(hif.freeze), 32'd1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("tmo_rst_mem_err", 32'(hif.mem_err), 32'd0);
    chk("tmo_rst_stall_cnt", hif.stall_cnt, 32'd0);
    chk("tmo_rst_flush_cnt", hif.flush_cnt, 32'd0);
    cycle();

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      hif.id_rs1 = 5'($urandom_range(0, 3));
      hif.id_rs2 = 5'($urandom_range(0, 3));
      hif.id_use_rs1 = 1'($urandom_range(0, 1));
      hif.id_use_rs2 = 1'($urandom_range(0, 1));
      hif.ex_rd = 5'($urandom_range(0, 3));
      hif.ex_memread = 1'($urandom_range(0, 1));
      hif.ex_is_branch = 1'($urandom_range(0, 1));
      hif.ex_br_taken = 1'($urandom_range(0, 1));
      hif.ex_br_pred = 1'($urandom_range(0, 1));
      hif.mem_req = ($urandom_range(0, 9) < 3);
      hif.mem_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
